stream_demux_1x4: RTL and testbench

- Registered 1-to-4 stream demultiplexer: routes a single valid/ready input stream to one of four output channels.
- Destination is chosen by the `select` sampled on the first beat of each packet and held until the last beat.
- Each output channel has its own one-entry output register, so a stalled channel does not disturb the others.
- Sits on the fan-out side of the 4x1 selection path and returns per-channel traffic to independent consumers.

---
 rtl/stream_demux_1x4.sv | 133 +++++++++++++
 tb/tb_stream_demux_1x4.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1x4.sv
// -----------------------------------------------------------------------------
// stream_demux_1x4
//
// Purpose:
//   Registered 1-to-4 stream demultiplexer. A single valid/ready input stream
//   is routed to one of four output channels. The destination is taken from
//   `select` on the first beat of a packet and held until the last beat. Each
//   channel owns a one-entry output register, so a stalled consumer only
//   blocks traffic that is addressed to it.
//
// Ports:
//   clk       in   1         system clock, rising edge
//   rst_n     in   1         synchronous active-low reset
//   select    in   2         destination channel, sampled on packet header
//   d         in   DATA_W    input data beat
//   d_valid   in   1         input beat valid
//   d_last    in   1         input beat closes its packet
//   d_ready   out  1         input beat can be accepted this cycle
//   q         out  4*DATA_W  channel data, channel n at [n*DATA_W +: DATA_W]
//   q_valid   out  4         per-channel valid
//   q_last    out  4         per-channel last flag (qualified by q_valid)
//   q_ready   in   4         per-channel consumer ready
//   busy      out  1         packet locked (partway through)
//   pkt_done  out  1         pulse the cycle after a last beat is accepted
// -----------------------------------------------------------------------------
module stream_demux_1x4 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            select,
  input  logic [DATA_W-1:0]     d,
  input  logic                  d_valid,
  input  logic                  d_last,
  output logic                  d_ready,
  output logic [4*DATA_W-1:0]   q,
  output logic [3:0]            q_valid,
  output logic [3:0]            q_last,
  input  logic [3:0]            q_ready,
  output logic                  busy,
  output logic                  pkt_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_sel_q;
  logic [1:0]          w_sel_next;
  logic                r_pkt_done;
  logic [1:0]          w_ch;
  logic [3:0]          w_slot_free;
  logic                w_accept;
  logic [3:0]          r_q_valid;
  logic [3:0]          r_q_last;
  logic [DATA_W-1:0]   r_q_data [4];

  // The header beat routes on the live select; later beats use the latched one.
  assign w_ch        = (r_state == IDLE) ? select : r_sel_q;
  // A slot can take a new beat if it is empty or is being emptied this cycle.
  assign w_slot_free = ~r_q_valid | q_ready;
  // d_ready deliberately excludes d_valid so there is no valid->ready loop.
  assign d_ready     = w_slot_free[w_ch];
  assign w_accept    = d_valid & d_ready;

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel_q;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !d_last) begin
          w_state_next = LOCKED;
          w_sel_next   = select;
        end
      end
      LOCKED: begin
        if (w_accept && d_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel_q    <= 2'd0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sel_q    <= w_sel_next;
      r_pkt_done <= w_accept & d_last;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      localparam logic [1:0] CH = 2'(gi);
      logic w_load;

      assign w_load = w_accept && (w_ch == CH);

      // Load wins over drain so a draining slot can be refilled in the same
      // cycle, giving back-to-back beats at full rate.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q_valid[gi] <= 1'b0;
          r_q_last[gi]  <= 1'b0;
          r_q_data[gi]  <= '0;
        end else if (w_load) begin
          r_q_valid[gi] <= 1'b1;
          r_q_last[gi]  <= d_last;
          r_q_data[gi]  <= d;
        end else if (r_q_valid[gi] && q_ready[gi]) begin
          r_q_valid[gi] <= 1'b0;
        end
      end

      assign q[gi*DATA_W +: DATA_W] = r_q_data[gi];
    end
  endgenerate

  assign q_valid  = r_q_valid;
  assign q_last   = r_q_last;
  assign busy     = (r_state == LOCKED);
  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_stream_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1x4
//
// Directed testbench for stream_demux_1x4. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_stream_demux_1x4;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst_n;
  logic [1:0]          select;
  logic [DATA_W-1:0]   d;
  logic                d_valid;
  logic                d_last;
  logic                d_ready;
  logic [4*DATA_W-1:0] q;
  logic [3:0]          q_valid;
  logic [3:0]          q_last;
  logic [3:0]          q_ready;
  logic                busy;
  logic                pkt_done;

  int n_checks;
  int n_errors;

  stream_demux_1x4 #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .select   (select),
    .d        (d),
    .d_valid  (d_valid),
    .d_last   (d_last),
    .d_ready  (d_ready),
    .q        (q),
    .q_valid  (q_valid),
    .q_last   (q_last),
    .q_ready  (q_ready),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int n);
    return q[n*DATA_W +: DATA_W];
  endfunction

  // Advance one clock; report the beat if the input handshake completed.
  task automatic step();
    logic acc;
    logic [1:0] sel_s;
    logic [7:0] d_s;
    logic last_s;
    acc    = d_valid && d_ready && rst_n;
    sel_s  = select;
    d_s    = d;
    last_s = d_last;
    @(posedge clk);
    #1;
    if (acc)
      $display("[%0t] beat accepted: select=%0d d=0x%02h last=%0b", $time, sel_s, d_s, last_s);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    select   = 2'd0;
    d        = 8'hEE;
    d_valid  = 1'b1;
    d_last   = 1'b1;
    q_ready  = 4'h0;

    // Reset held for two cycles with d_valid high: nothing may load.
    step();
    step();
    check_eq("rst_q_valid",  32'(q_valid), 32'h0);
    check_eq("rst_q_last",   32'(q_last), 32'h0);
    check_eq("rst_q",        32'(q), 32'h0);
    check_eq("rst_busy",     32'(busy), 32'h0);
    check_eq("rst_pkt_done", 32'(pkt_done), 32'h0);
    check_eq("rst_d_ready",  32'(d_ready), 32'h1);
    d_valid = 1'b0;
    rst_n   = 1'b1;
    step();
    check_eq("rst_no_load",  32'(q_valid), 32'h0);

    // Single-beat packets to every channel, back to back.
    q_ready = 4'hF;
    for (int s = 0; s < 4; s++) begin
      select  = 2'(s);
      d       = 8'hA5;
      d_last  = 1'b1;
      d_valid = 1'b1;
      #1;
      check_eq($sformatf("sb%0d_d_ready", s), 32'(d_ready), 32'h1);
      step();
      check_eq($sformatf("sb%0d_q_valid", s), 32'(q_valid), 32'(4'b0001 << s));
      check_eq($sformatf("sb%0d_q", s), 32'(chan(s)), 32'hA5);
      check_eq($sformatf("sb%0d_q_last", s), 32'(q_last[s]), 32'h1);
      check_eq($sformatf("sb%0d_pkt_done", s), 32'(pkt_done), 32'h1);
      check_eq($sformatf("sb%0d_busy", s), 32'(busy), 32'h0);
    end
    d_valid = 1'b0;
    step();
    check_eq("sb_idle_q_valid",  32'(q_valid), 32'h0);
    check_eq("sb_idle_pkt_done", 32'(pkt_done), 32'h0);

    // Packet lock: select moves to 0 after the header, beats stay on ch 2.
    select  = 2'd2;
    d       = 8'h10;
    d_last  = 1'b0;
    d_valid = 1'b1;
    step();
    check_eq("lock_b0_q_valid", 32'(q_valid), 32'h4);
    check_eq("lock_b0_q",       32'(chan(2)), 32'h10);
    check_eq("lock_b0_busy",    32'(busy), 32'h1);
    check_eq("lock_b0_done",    32'(pkt_done), 32'h0);
    select = 2'd0;
    d      = 8'h11;
    step();
    check_eq("lock_b1_q_valid", 32'(q_valid), 32'h4);
    check_eq("lock_b1_q",       32'(chan(2)), 32'h11);
    check_eq("lock_b1_last",    32'(q_last[2]), 32'h0);
    check_eq("lock_b1_busy",    32'(busy), 32'h1);
    d      = 8'h12;
    d_last = 1'b1;
    step();
    check_eq("lock_b2_q_valid", 32'(q_valid), 32'h4);
    check_eq("lock_b2_q",       32'(chan(2)), 32'h12);
    check_eq("lock_b2_last",    32'(q_last[2]), 32'h1);
    check_eq("lock_b2_busy",    32'(busy), 32'h0);
    check_eq("lock_b2_done",    32'(pkt_done), 32'h1);
    check_eq("lock_ch0_q",      32'(chan(0)), 32'hA5);
    d_valid = 1'b0;
    step();
    check_eq("lock_end_q_valid", 32'(q_valid), 32'h0);

    // Backpressure on channel 1.
    q_ready = 4'b1101;
    select  = 2'd1;
    d       = 8'h01;
    d_last  = 1'b0;
    d_valid = 1'b1;
    #1;
    check_eq("bp_b0_d_ready", 32'(d_ready), 32'h1);
    step();
    check_eq("bp_b0_q_valid", 32'(q_valid), 32'h2);
    check_eq("bp_b0_q",       32'(chan(1)), 32'h01);
    d      = 8'h02;
    d_last = 1'b1;
    #1;
    check_eq("bp_b1_d_ready", 32'(d_ready), 32'h0);
    step();
    check_eq("bp_hold1_q",       32'(chan(1)), 32'h01);
    check_eq("bp_hold1_q_valid", 32'(q_valid), 32'h2);
    check_eq("bp_hold1_last",    32'(q_last[1]), 32'h0);
    check_eq("bp_hold1_busy",    32'(busy), 32'h1);
    step();
    check_eq("bp_hold2_q",       32'(chan(1)), 32'h01);
    check_eq("bp_hold2_d_ready", 32'(d_ready), 32'h0);
    q_ready = 4'hF;
    #1;
    check_eq("bp_release_d_ready", 32'(d_ready), 32'h1);
    step();
    check_eq("bp_b1_q",       32'(chan(1)), 32'h02);
    check_eq("bp_b1_q_valid", 32'(q_valid), 32'h2);
    check_eq("bp_b1_last",    32'(q_last[1]), 32'h1);
    check_eq("bp_b1_done",    32'(pkt_done), 32'h1);
    d_valid = 1'b0;
    step();
    check_eq("bp_end_q_valid", 32'(q_valid), 32'h0);

    // Independence: channel 3 holds a stalled beat while channel 0 flows.
    q_ready = 4'b0111;
    select  = 2'd3;
    d       = 8'h33;
    d_last  = 1'b1;
    d_valid = 1'b1;
    step();
    check_eq("ind_ch3_q_valid", 32'(q_valid), 32'h8);
    #1;
    check_eq("ind_ch3_d_ready", 32'(d_ready), 32'h0);
    select = 2'd0;
    d      = 8'h40;
    d_last = 1'b0;
    #1;
    check_eq("ind_ch0_d_ready", 32'(d_ready), 32'h1);
    step();
    check_eq("ind_b0_q_valid", 32'(q_valid), 32'h9);
    check_eq("ind_b0_q0",      32'(chan(0)), 32'h40);
    check_eq("ind_b0_q3",      32'(chan(3)), 32'h33);
    d      = 8'h41;
    d_last = 1'b1;
    step();
    check_eq("ind_b1_q_valid", 32'(q_valid), 32'h9);
    check_eq("ind_b1_q0",      32'(chan(0)), 32'h41);
    check_eq("ind_b1_q3",      32'(chan(3)), 32'h33);
    check_eq("ind_b1_last3",   32'(q_last[3]), 32'h1);
    d_valid = 1'b0;
    step();
    check_eq("ind_drain_q_valid", 32'(q_valid), 32'h8);
    check_eq("ind_drain_q3",      32'(chan(3)), 32'h33);
    q_ready = 4'hF;
    step();
    check_eq("ind_end_q_valid", 32'(q_valid), 32'h0);

    // Reset in the middle of a packet to channel 1.
    q_ready = 4'b1101;
    select  = 2'd1;
    d       = 8'h50;
    d_last  = 1'b0;
    d_valid = 1'b1;
    step();
    q_ready = 4'hF;
    d       = 8'h51;
    step();
    check_eq("mr_pre_busy",    32'(busy), 32'h1);
    check_eq("mr_pre_q_valid", 32'(q_valid), 32'h2);
    rst_n   = 1'b0;
    d_valid = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mr_q_valid",  32'(q_valid), 32'h0);
    check_eq("mr_busy",     32'(busy), 32'h0);
    check_eq("mr_pkt_done", 32'(pkt_done), 32'h0);
    select  = 2'd3;
    d       = 8'h77;
    d_last  = 1'b1;
    d_valid = 1'b1;
    step();
    check_eq("mr_new_q_valid", 32'(q_valid), 32'h8);
    check_eq("mr_new_q3",      32'(chan(3)), 32'h77);
    check_eq("mr_new_last3",   32'(q_last[3]), 32'h1);
    check_eq("mr_new_done",    32'(pkt_done), 32'h1);
    check_eq("mr_new_busy",    32'(busy), 32'h0);
    d_valid = 1'b0;
    step();
    check_eq("mr_end_q_valid", 32'(q_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
